// File: rtl/pwl_act_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwl_act_pkg : slope-code layout, cfg selects, softplus defaults    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pwl_act_pkg;

  localparam int c_slope_w   = 9;
  localparam int c_a_en_bit  = 8;
  localparam int c_a_sh_lsb  = 5;
  localparam int c_b_en_bit  = 4;
  localparam int c_b_neg_bit = 3;
  localparam int c_b_sh_lsb  = 0;
  localparam int c_sh_w      = 3;

  localparam logic [1:0] c_sel_bp    = 2'd0;
  localparam logic [1:0] c_sel_slope = 2'd1;
  localparam logic [1:0] c_sel_icpt  = 2'd2;

  // Softplus table in Q4.15; applies only when the table has 8 segments.
  localparam int c_def_seg = 8;
  localparam logic signed [19:0] c_def_bp [8] = '{
    20'shE8000, 20'shF4000, 20'shFC000, 20'sh04000,
    20'sh06000, 20'sh0C000, 20'sh16000, 20'sh7FFFF};
  localparam logic [c_slope_w-1:0] c_def_slope [8] = '{
    9'h000, 9'h160, 9'h140, 9'h120, 9'h133, 9'h132, 9'h11B, 9'h100};
  localparam logic signed [19:0] c_def_icpt [8] = '{
    20'sh00000, 20'sh03000, 20'sh04800, 20'sh05800,
    20'sh05000, 20'sh04400, 20'sh02C00, 20'sh00000};

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwl_seg_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwl_seg_table : segment register file with defaults and write port |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pwl_seg_table
  import pwl_act_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int SEG    = 8,
  parameter int SEG_W  = $clog2(SEG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [1:0]               i_sel,
  input  logic [SEG_W-1:0]         i_addr,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [SEG_W-1:0]         i_rd_idx,
  output logic signed [DATA_W-1:0] o_bp [SEG],
  output logic [c_slope_w-1:0]     o_slope,
  output logic signed [DATA_W-1:0] o_icpt
);

  logic signed [DATA_W-1:0] r_bp    [SEG];
  logic signed [DATA_W-1:0] r_icpt  [SEG];
  logic [c_slope_w-1:0]     r_slope [SEG];

  logic signed [DATA_W-1:0] w_def_bp    [SEG];
  logic signed [DATA_W-1:0] w_def_icpt  [SEG];
  logic [c_slope_w-1:0]     w_def_slope [SEG];

  for (genvar g = 0; g < SEG; g++) begin : g_def
    if (SEG == c_def_seg) begin : g_softplus
      assign w_def_bp[g]    = DATA_W'(c_def_bp[g]);
      assign w_def_icpt[g]  = DATA_W'(c_def_icpt[g]);
      assign w_def_slope[g] = c_def_slope[g];
    end else begin : g_flat
      assign w_def_bp[g]    = {1'b0, {(DATA_W-1){1'b1}}};
      assign w_def_icpt[g]  = '0;
      assign w_def_slope[g] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEG; i++) begin
        r_bp[i]    <= w_def_bp[i];
        r_icpt[i]  <= w_def_icpt[i];
        r_slope[i] <= w_def_slope[i];
      end
    end else if (i_we && (int'(i_addr) < SEG)) begin
      case (i_sel)
        c_sel_bp:    r_bp[i_addr]    <= i_data;
        c_sel_slope: r_slope[i_addr] <= i_data[c_slope_w-1:0];
        c_sel_icpt:  r_icpt[i_addr]  <= i_data;
        default:     ;
      endcase
    end
  end

  assign o_bp    = r_bp;
  assign o_slope = r_slope[i_rd_idx];
  assign o_icpt  = r_icpt[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/pwl_act_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwl_act_pipe : 3-stage streaming piecewise-linear activation unit  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pwl_act_pipe
  import pwl_act_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int SEG    = 8,
  parameter int SEG_W  = $clog2(SEG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic signed [DATA_W-1:0] i_in_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic signed [DATA_W-1:0] o_out_data,
  output logic [SEG_W-1:0]         o_out_seg,
  input  logic                     i_cfg_we,
  input  logic [1:0]               i_cfg_sel,
  input  logic [SEG_W-1:0]         i_cfg_addr,
  input  logic [DATA_W-1:0]        i_cfg_data,
  output logic                     o_cfg_ready
);

  logic                     w_s1_en, w_s2_en, w_s3_en, w_cfg_wr, w_accept;
  logic                     r_s1_valid, r_s2_valid, r_out_valid;
  logic signed [DATA_W-1:0] r_s1_x;
  logic [SEG_W-1:0]         r_s1_seg, r_s2_seg, r_out_seg, w_seg;
  logic signed [DATA_W-1:0] r_s2_a, r_s2_c, r_out_data;
  logic signed [DATA_W:0]   r_s2_b;

  logic signed [DATA_W-1:0] w_bp [SEG];
  logic [c_slope_w-1:0]     w_slope;
  logic signed [DATA_W-1:0] w_icpt;
  logic signed [DATA_W-1:0] w_shr_a, w_shr_b, w_term_a, w_term_b_mag, w_sat;
  logic signed [DATA_W:0]   w_term_b;
  logic signed [DATA_W+1:0] w_sum;

  // A stage may load when its own slot is empty or its content moves on.
  assign w_s3_en     = !r_out_valid || i_out_ready;
  assign w_s2_en     = !r_s2_valid || w_s3_en;
  assign w_s1_en     = !r_s1_valid || w_s2_en;
  assign o_cfg_ready = !(r_s1_valid || r_s2_valid || r_out_valid);
  assign w_cfg_wr    = i_cfg_we && o_cfg_ready;
  assign o_in_ready  = w_s1_en && !w_cfg_wr;
  assign w_accept    = i_in_valid && o_in_ready;

  pwl_seg_table #(.DATA_W(DATA_W), .SEG(SEG), .SEG_W(SEG_W)) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_cfg_wr),
    .i_sel    (i_cfg_sel),
    .i_addr   (i_cfg_addr),
    .i_data   (i_cfg_data),
    .i_rd_idx (r_s1_seg),
    .o_bp     (w_bp),
    .o_slope  (w_slope),
    .o_icpt   (w_icpt)
  );

  // Scanning downward leaves the lowest matching index as the winner.
  always_comb begin
    w_seg = SEG_W'(SEG - 1);
    for (int i = SEG - 2; i >= 0; i--) begin
      if (i_in_data <= w_bp[i]) w_seg = SEG_W'(i);
    end
  end

  assign w_shr_a      = r_s1_x >>> w_slope[c_a_sh_lsb +: c_sh_w];
  assign w_shr_b      = r_s1_x >>> w_slope[c_b_sh_lsb +: c_sh_w];
  assign w_term_a     = w_slope[c_a_en_bit] ? w_shr_a : '0;
  assign w_term_b_mag = w_slope[c_b_en_bit] ? w_shr_b : '0;
  assign w_term_b     = w_slope[c_b_neg_bit] ? -(DATA_W+1)'(w_term_b_mag)
                                             :  (DATA_W+1)'(w_term_b_mag);

  assign w_sum = (DATA_W+2)'(r_s2_a) + (DATA_W+2)'(r_s2_b) + (DATA_W+2)'(r_s2_c);
  assign w_sat = DATA_W'(sat(64'(w_sum), DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_seg    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_a      <= '0;
      r_s2_b      <= '0;
      r_s2_c      <= '0;
      r_s2_seg    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_seg   <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_x   <= i_in_data;
          r_s1_seg <= w_seg;
        end
      end
      if (w_s2_en) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_a   <= w_term_a;
          r_s2_b   <= w_term_b;
          r_s2_c   <= w_icpt;
          r_s2_seg <= r_s1_seg;
        end
      end
      if (w_s3_en) begin
        r_out_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_out_data <= w_sat;
          r_out_seg  <= r_s2_seg;
        end
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_seg   = r_out_seg;

endmodule
`default_nettype wire

// File: tb/tb_pwl_act_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pwl_act_pipe : scoreboard bench for pwl_act_pipe                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pwl_act_pipe;

  localparam int DATA_W = 20;
  localparam int SEG    = 8;
  localparam int SEG_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_in_data = '0;
  logic              o_out_valid;
  logic              i_out_ready = 1'b1;
  logic [DATA_W-1:0] o_out_data;
  logic [SEG_W-1:0]  o_out_seg;
  logic              i_cfg_we = 1'b0;
  logic [1:0]        i_cfg_sel = '0;
  logic [SEG_W-1:0]  i_cfg_addr = '0;
  logic [DATA_W-1:0] i_cfg_data = '0;
  logic              o_cfg_ready;

  always #5 clk = ~clk;

  pwl_act_pipe #(.DATA_W(DATA_W), .SEG(SEG), .SEG_W(SEG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_seg   (o_out_seg),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_sel   (i_cfg_sel),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_data  (i_cfg_data),
    .o_cfg_ready (o_cfg_ready)
  );

  typedef struct { logic [19:0] y; logic [2:0] seg; int acc; } exp_t;
  typedef struct { logic [19:0] x; logic [19:0] y; logic [2:0] seg; } vec_t;

  exp_t q[$];
  exp_t e;
  vec_t vt[7];
  int   n_cmp = 0, n_err = 0, cyc = 0, n_out = 0, n0 = 0;
  bit   chk_lat = 1'b0, done = 1'b0, stall_prev = 1'b0;
  logic [19:0] prev_d, rx;
  logic [2:0]  prev_s;

  // Independent golden model of the segment table and datapath.
  longint      m_bp[8], m_ic[8];
  logic [8:0]  m_sl[8];

  function automatic longint sx(input logic [19:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [8:0] code(input bit ae, input int as, input bit be, input bit bn, input int bs);
    logic [8:0] c;
    c = {ae, 3'(as), be, bn, 3'(bs)};
    return c;
  endfunction

  task automatic m_reset();
    m_bp[0] = sx(20'hE8000); m_bp[1] = sx(20'hF4000); m_bp[2] = sx(20'hFC000);
    m_bp[3] = sx(20'h04000); m_bp[4] = sx(20'h06000); m_bp[5] = sx(20'h0C000);
    m_bp[6] = sx(20'h16000); m_bp[7] = sx(20'h7FFFF);
    m_ic[0] = 0;             m_ic[1] = sx(20'h03000); m_ic[2] = sx(20'h04800);
    m_ic[3] = sx(20'h05800); m_ic[4] = sx(20'h05000); m_ic[5] = sx(20'h04400);
    m_ic[6] = sx(20'h02C00); m_ic[7] = 0;
    m_sl[0] = '0;
    m_sl[1] = code(1, 3, 0, 0, 0);
    m_sl[2] = code(1, 2, 0, 0, 0);
    m_sl[3] = code(1, 1, 0, 0, 0);
    m_sl[4] = code(1, 1, 1, 0, 3);
    m_sl[5] = code(1, 1, 1, 0, 2);
    m_sl[6] = code(1, 0, 1, 1, 3);
    m_sl[7] = code(1, 0, 0, 0, 0);
  endtask

  function automatic int m_seg(input logic [19:0] x);
    for (int i = 0; i < SEG - 1; i++) if (sx(x) <= m_bp[i]) return i;
    return SEG - 1;
  endfunction

  function automatic logic [19:0] m_y(input logic [19:0] x);
    int     s;
    longint a, b, v;
    s = m_seg(x);
    a = m_sl[s][8] ? (sx(x) >>> m_sl[s][7:5]) : 0;
    b = m_sl[s][4] ? (sx(x) >>> m_sl[s][2:0]) : 0;
    if (m_sl[s][3]) b = -b;
    v = a + b + m_ic[s];
    if (v > 524287) v = 524287;
    if (v < -524288) v = -524288;
    return v[19:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [19:0] x, input logic [19:0] ey, input logic [2:0] es);
    @(posedge clk); #1;
    i_in_valid = 1'b1;
    i_in_data  = x;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (o_in_ready) begin
        q.push_back(exp_t'{y: ey, seg: es, acc: cyc});
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++; n_err++;
    $display("FAIL accept_timeout: got no in_ready, want accept of %0h", x);
    i_in_valid = 1'b0;
  endtask

  task automatic in_idle();
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (q.size() == 0 && o_cfg_ready) return;
    end
    n_cmp++; n_err++;
    $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [2:0] addr, input logic [19:0] data, input bit exp_ok);
    @(posedge clk); #1;
    i_in_valid = exp_ok;
    i_cfg_we   = 1'b1;
    i_cfg_sel  = sel;
    i_cfg_addr = addr;
    i_cfg_data = data;
    @(negedge clk);
    check("cfg_ready", {31'b0, o_cfg_ready}, {31'b0, exp_ok});
    if (exp_ok) check("in_ready_during_cfg", {31'b0, o_in_ready}, 32'd0);
    @(posedge clk); #1;
    i_cfg_we   = 1'b0;
    i_in_valid = 1'b0;
    if (exp_ok) begin
      case (sel)
        2'd0:    m_bp[addr] = sx(data);
        2'd1:    m_sl[addr] = data[8:0];
        2'd2:    m_ic[addr] = sx(data);
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: in-order scoreboard, latency and stall-hold checks.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {31'b0, o_out_valid}, 32'd1);
        check("hold_data", {12'b0, o_out_data}, {12'b0, prev_d});
        check("hold_seg", {29'b0, o_out_seg}, {29'b0, prev_s});
      end
      if (o_out_valid && i_out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got %0h, want no output", o_out_data);
        end else begin
          e = q.pop_front();
          check("out_data", {12'b0, o_out_data}, {12'b0, e.y});
          check("out_seg", {29'b0, o_out_seg}, {29'b0, e.seg});
          if (chk_lat) check("latency", cyc - e.acc, 32'd3);
        end
      end
      stall_prev = o_out_valid && !i_out_ready;
      prev_d     = o_out_data;
      prev_s     = o_out_seg;
    end
  end

  initial begin
    vt[0] = '{x: 20'h00000, y: 20'h05800, seg: 3'd3};
    vt[1] = '{x: 20'hE0000, y: 20'h00000, seg: 3'd0};
    vt[2] = '{x: 20'h08000, y: 20'h0A400, seg: 3'd5};
    vt[3] = '{x: 20'h18000, y: 20'h18000, seg: 3'd7};
    vt[4] = '{x: 20'hF4000, y: 20'h01800, seg: 3'd1};
    vt[5] = '{x: 20'hF4001, y: 20'h01800, seg: 3'd2};
    vt[6] = '{x: 20'h16000, y: 20'h16000, seg: 3'd6};
    m_reset();

    #3;
    check("rst_out_valid", {31'b0, o_out_valid}, 32'd0);
    check("rst_out_data", {12'b0, o_out_data}, 32'd0);
    check("rst_out_seg", {29'b0, o_out_seg}, 32'd0);
    check("rst_cfg_ready", {31'b0, o_cfg_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Default softplus table, isolated samples with exact latency.
    chk_lat = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send(vt[k].x, vt[k].y, vt[k].seg);
      in_idle();
      wait_empty();
    end

    // Random stream under ~40% backpressure.
    chk_lat = 1'b0;
    n0      = n_out;
    done    = 1'b0;
    fork
      begin
        while (!done) begin
          @(posedge clk); #1;
          i_out_ready = ($urandom_range(0, 99) >= 40);
        end
      end
      begin
        for (int k = 0; k < 200; k++) begin
          if ($urandom_range(0, 1) == 1) rx = 20'($urandom_range(0, 20'hFFFFF));
          else rx = 20'(m_bp[$urandom_range(0, 6)]) + 20'($urandom_range(0, 4)) - 20'd2;
          send(rx, m_y(rx), 3'(m_seg(rx)));
          if ($urandom_range(0, 4) == 0) in_idle();
        end
        in_idle();
        wait_empty();
        done = 1'b1;
      end
    join
    i_out_ready = 1'b1;
    check("stream_count", n_out - n0, 32'd200);

    // Config write while samples are in flight is dropped; retry lands.
    chk_lat = 1'b1;
    send(20'h00000, 20'h05800, 3'd3);
    send(20'h00000, 20'h05800, 3'd3);
    cfg_write(2'd2, 3'd3, 20'h00000, 1'b0);
    wait_empty();
    send(20'h00000, 20'h05800, 3'd3);
    in_idle();
    wait_empty();
    cfg_write(2'd2, 3'd3, 20'h00000, 1'b1);
    send(20'h00000, 20'h00000, 3'd3);
    in_idle();
    wait_empty();

    // Saturation at both rails.
    cfg_write(2'd2, 3'd7, 20'h7FFFF, 1'b1);
    send(20'h7FFFF, 20'h7FFFF, 3'd7);
    in_idle();
    wait_empty();
    cfg_write(2'd1, 3'd0, 20'h00100, 1'b1);
    cfg_write(2'd2, 3'd0, 20'h80000, 1'b1);
    send(20'h80000, 20'h80000, 3'd0);
    in_idle();
    wait_empty();

    // Reset with three samples in flight.
    chk_lat     = 1'b0;
    i_out_ready = 1'b0;
    send(20'h01000, m_y(20'h01000), 3'(m_seg(20'h01000)));
    send(20'h02000, m_y(20'h02000), 3'(m_seg(20'h02000)));
    send(20'h03000, m_y(20'h03000), 3'(m_seg(20'h03000)));
    in_idle();
    check("pre_rst_out_valid", {31'b0, o_out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, o_out_valid}, 32'd0);
    check("midrst_cfg_ready", {31'b0, o_cfg_ready}, 32'd1);
    q.delete();
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    i_out_ready = 1'b1;
    chk_lat     = 1'b1;
    send(20'h00000, 20'h05800, 3'd3);
    in_idle();
    wait_empty();
    send(20'h80000, 20'h00000, 3'd0);
    in_idle();
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwl_act_pipe.md
Name: pwl_act_pipe

Overview:
- Pipelined, streaming piecewise-linear activation unit with a programmable segment table. Output per segment is y = M*x + C, with M built from one or two shift terms.
- Successor of the fixed 8-segment softplus approximator. Adds a valid/ready stream interface, a 3-stage pipeline, a runtime-loadable table, parametrised width and segment count, and output saturation.
- Sits between the var stage and the downstream consumer.
- Resets to the softplus table, so the block is a drop-in replacement.

Parameters:
- DATA_W, 20, signed sample width. Q(DATA_W-16).15 format; DATA_W >= 20.
- SEG, 8, number of segments, 2..16.
- SEG_W, $clog2(SEG), segment index / config address width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_data  in  DATA_W  signed input x.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  signed result y, saturated.
- out_seg  out  SEG_W  segment index used for this result.
- cfg_we  in  1  table write strobe.
- cfg_sel  in  2  0 = breakpoint, 1 = slope code, 2 = intercept, 3 = ignored.
- cfg_addr  in  SEG_W  segment index.
- cfg_data  in  DATA_W  write data; slope code uses bits [8:0].
- cfg_ready  out  1  high when the pipeline is empty and the write will be accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_data=0, out_seg=0, all stage valids=0.
- Reset table, when SEG==8, values sign-extended to DATA_W:
  - Breakpoints bp[0..6] = E8000, F4000, FC000, 04000, 06000, 0C000, 16000. bp[7] is unused.
  - Intercepts = 00000, 03000, 04800, 05800, 05000, 04400, 02C00, 00000.
  - Slopes: seg0 none, seg1 >>>3, seg2 >>>2, seg3 >>>1, seg4 >>>1 + >>>3, seg5 >>>1 + >>>2, seg6 >>>0 - >>>3, seg7 >>>0.
- Reset table, when SEG != 8: every bp = most positive value, every slope = none, every intercept = 0.
- Slope code, 9 bits: [8] a_en, [7:5] a_sh, [4] b_en, [3] b_neg, [2:0] b_sh.
  - M*x = (a_en ? x>>>a_sh : 0) ± (b_en ? x>>>b_sh : 0).
  - Shifts are arithmetic.
- Segment select: the lowest i with x <= bp[i], over i in 0..SEG-2. If none matches, i = SEG-1. The compare is signed.
- Pipeline, latency exactly 3 cycles from accept to out_valid when there is no backpressure:
  - S1 registers x and the segment index.
  - S2 registers term_a, term_b and the intercept.
  - S3 computes the sum at DATA_W+2 bits, saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then registers it.
- Flow control: each stage advances when its downstream slot is empty or being drained.
  - in_ready = (S1 empty or S1 advancing) && !cfg_write_this_cycle.
  - Full throughput of 1 sample/cycle when out_ready is held high.
  - While out_ready=0 and out_valid=1, out_data and out_seg are held stable and no sample is lost or duplicated.
- Config writes:
  - cfg_ready = !(S1|S2|S3 valid).
  - A write with cfg_we && cfg_ready updates the table at the clock edge.
  - in_ready is forced to 0 in that cycle, so a write and a sample accept never coincide.
  - cfg_we with cfg_ready=0 is ignored; no queueing.
  - A write to bp[SEG-1] is stored but unused.
- Table semantics: the table is read only in S1 (bp) and S2 (slope, intercept). Because writes only occur when the pipeline is empty, each sample sees one consistent table.
- Boundaries:
  - x equal to bp[i] selects segment i.
  - Non-monotonic breakpoints are legal; the lowest-index rule still applies.
- Reset mid-stream: in-flight samples are discarded and the table returns to its defaults.

Decomposition:
- Package pwl_act_pkg holds:
  - the slope-code field widths and offsets;
  - cfg_sel encodings;
  - the default softplus breakpoint, slope and intercept constants (Q4.15);
  - a saturate function.
- Sub-module pwl_seg_table: register file with the reset defaults, write port and combinational read of all breakpoints plus the indexed slope and intercept.
- Pipeline and flow control live in the top module.

Test Plan:
- Reset defaults, single samples:
  - x=00000 -> y=05800, seg=3.
  - x=E0000 -> y=00000, seg=0.
  - x=08000 -> y=0A400, seg=5.
  - x=18000 -> y=18000, seg=7.
  - Each output arrives exactly 3 cycles after accept.
- Breakpoint edges: x=F4000 -> seg1, y=F4000>>>3+03000. x=F4001 -> seg2. x=16000 -> seg6, y=16000-02C00+02C00.
- Streaming with random out_ready (~40% low), 200 random samples -> outputs in order, match the golden model, none dropped, held stable while stalled.
- Saturation: write intercept[7]=7FFFF while cfg_ready=1, then x=7FFFF -> y=7FFFF. Also x=80000 at seg0 with intercept 80000 and slope >>>0 -> y=80000.
- Config gating:
  - Assert cfg_we while 2 samples are in flight -> write ignored and the table is unchanged.
  - Retry once empty -> accepted, and in_ready=0 in that cycle.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight -> out_valid=0 immediately, and after release the default table is restored (x=00000 -> 05800).
